sprite_scheduler: RTL
=====================

# sprite_scheduler

Owns a small bank of bouncing rectangle "sprites" for the 640x480 VGA pipeline and is the single place where their state is configured, advanced and composited. A host writes slot configuration through a valid/ready port. On each end-of-frame animate pulse, one shared step engine advances every enabled slot, one slot per pixel strobe. A priority compositor turns the current raster position into a registered 12-bit colour for the VGA output pins.

## Interface
- N_SLOTS, 4, number of sprite slots (power of two, 2..8)
- H_RES, 640, active width in pixels
- V_RES, 480, active height in lines
- i_clk  in  1  system clock (100 MHz)
- i_rst  in  1  reset, asynchronous, active-low
- i_pix_stb  in  1  pixel strobe, one i_clk cycle wide (25 MHz rate)
- i_animate  in  1  end-of-active-frame pulse, aligned to i_pix_stb
- i_x  in  10  current raster x
- i_y  in  9  current raster y
- i_cfg_valid  in  1  config write request
- o_cfg_ready  out  1  config write accepted when high with i_cfg_valid
- i_cfg_slot  in  $clog2(N_SLOTS)  target slot
- i_cfg_x, i_cfg_y  in  12 each  centre position
- i_cfg_hsize  in  8  half-size of the square
- i_cfg_dx_pos, i_cfg_dy_pos  in  1 each  initial direction (1 = increasing)
- i_cfg_en  in  1  slot enable
- i_cfg_color  in  12  {R,G,B} 4 bits each
- o_rgb  out  12  composited pixel colour
- o_hit  out  1  some enabled slot covers the pixel
- o_busy  out  1  update sweep in progress

## Operation
- Per-slot state: x, y (12b), hsize (8b), dx_pos, dy_pos, en, color.
- FSM IDLE -> SWEEP -> IDLE; index register idx.
- IDLE: o_cfg_ready=1, o_busy=0. i_animate -> SWEEP, idx=0.
- SWEEP: o_cfg_ready=0, o_busy=1. On each i_pix_stb, slot[idx] is stepped if en (disabled slots are skipped but still consume the strobe). idx increments. After idx==N_SLOTS-1 is processed -> IDLE.
- Step per axis (R = H_RES or V_RES, h = hsize, zero-extended to 12b): p' = dir ? p+1 : p-1.
  - If p' <= h+1 then dir=1.
  - Else if p' >= R-h-1 then dir=0.
  - Arithmetic is unsigned 12-bit. A config that places p out of range self-corrects by one pixel per frame and is not clamped.
- Config write: when i_cfg_valid & o_cfg_ready, all fields of slot i_cfg_slot are written on that edge.
- Compositor, evaluated on each i_pix_stb:
  - Slot hits when en, x-h < i_x < x+h, and y-h < i_y < y+h (strict).
  - o_rgb <= color of the lowest-index hitting slot, else 0.
  - o_hit <= any hit.
- Boundaries:
  - i_animate during SWEEP is ignored.
  - i_animate and an accepted write in the same IDLE cycle: the write lands, SWEEP starts next cycle, and the sweep uses the new values.
  - i_cfg_valid held during SWEEP waits and is accepted in the first IDLE cycle.
  - Two slots with identical geometry: the lower index wins.

## Timing
- Reset (i_rst low, asynchronous): state IDLE, idx 0, every slot en=0, x=y=0, hsize=0, dx_pos=dy_pos=1, color 0. o_rgb=0, o_hit=0, o_busy=0, o_cfg_ready=1 (writes are blocked while reset is held).
- Compositor latency: o_rgb/o_hit reflect the (i_x,i_y) sampled at a strobe, valid from the next i_clk edge until the next strobe.
- Sweep length: N_SLOTS strobes after the i_animate strobe. o_busy rises the cycle after i_animate and falls the cycle after the last slot's strobe. This completes well inside vertical blanking.
- Reset mid-SWEEP: the sweep aborts and all slot state returns to reset values.

## Structure
- Package sprite_pkg:
  - COORD_W=12, COLOR_W=12, HSIZE_W=8
  - slot_t struct {x, y, hsize, dx_pos, dy_pos, en, color}
  - state enum {IDLE, SWEEP}
- Sub-module sprite_axis_step: combinational p/dir/h/R -> p'/dir', instanced twice (x with H_RES, y with V_RES).
- Top holds the slot array, FSM and compositor priority loop (roughly 200 lines).

## Test plan
- Reset, no config, full frame of strobes -> o_rgb=0 and o_hit=0 everywhere; o_cfg_ready=1.
- Write slot0 {x=160, y=120, h=60, dx=1, dy=1, en, color=12'hF00}, pixel (160,120) -> o_rgb=F00 one cycle after the strobe; pixel (100,120) (edge, strict) -> 0.
- Slot0 at x=578, h=60, dx=1, one animate -> x=579, dx_pos=0; next animate -> x=578.
- Slots 0 and 1 both covering (320,240), colors F00/0F0 -> o_rgb=F00; disable slot0 -> 0F0.
- Animate with N_SLOTS=4: o_busy high for exactly 4 strobes; a second i_animate mid-sweep leaves each slot stepped only once; i_cfg_valid held during the sweep is accepted on the first IDLE cycle.
- Assert i_rst low during SWEEP, with no clock edge -> outputs and slot state return to reset values immediately.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types and geometry helpers for the sprite scheduler.
// Slot record, FSM encoding and the strict-inequality span test used by the compositor.
package sprite_pkg;

    localparam int COORD_W = 12;
    localparam int COLOR_W = 12;
    localparam int HSIZE_W = 8;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [HSIZE_W-1:0] hsize;
        logic               dx_pos;
        logic               dy_pos;
        logic               en;
        logic [COLOR_W-1:0] color;
    } slot_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_e;

    localparam slot_t SLOT_RESET = '{
        x:      '0,
        y:      '0,
        hsize:  '0,
        dx_pos: 1'b1,
        dy_pos: 1'b1,
        en:     1'b0,
        color:  '0
    };

    // Signed 14-bit compare so centre-h below zero does not wrap around.
    function automatic logic span_hit(
        input logic [COORD_W-1:0] centre,
        input logic [HSIZE_W-1:0] half,
        input logic [COORD_W-1:0] pix
    );
        logic signed [13:0] lo;
        logic signed [13:0] hi;
        logic signed [13:0] ps;
        lo = $signed({2'b00, centre}) - $signed({6'b000000, half});
        hi = $signed({2'b00, centre}) + $signed({6'b000000, half});
        ps = $signed({2'b00, pix});
        return (ps > lo) && (ps < hi);
    endfunction

endpackage

// File: rtl/sprite_axis_step.sv
// One-axis bounce step: move one pixel in the current direction, then turn at either wall.
// Purely combinational; the wall test uses the already-moved coordinate.
module sprite_axis_step #(
    parameter int RES = 640
) (
    input  logic [11:0] p_i,
    input  logic        dir_i,
    input  logic [7:0]  h_i,
    output logic [11:0] p_o,
    output logic        dir_o
);

    localparam logic [11:0] RES_W = RES[11:0];

    logic [11:0] h_ext;
    logic [11:0] p_n;
    logic [11:0] lo_lim;
    logic [11:0] hi_lim;

    always_comb begin
        h_ext  = {4'b0000, h_i};
        p_n    = dir_i ? (p_i + 12'd1) : (p_i - 12'd1);
        lo_lim = h_ext + 12'd1;
        hi_lim = RES_W - h_ext - 12'd1;
        dir_o  = dir_i;
        if (p_n <= lo_lim) begin
            dir_o = 1'b1;
        end else if (p_n >= hi_lim) begin
            dir_o = 1'b0;
        end
        p_o = p_n;
    end

endmodule

// File: rtl/sprite_scheduler.sv
// Sprite slot bank: host config port, per-frame step sweep (one slot per pixel strobe), priority compositor.
// Config is back-pressured (o_cfg_ready low) for the N_SLOTS-strobe sweep; compositor output is registered per strobe.
module sprite_scheduler
    import sprite_pkg::*;
#(
    parameter int N_SLOTS = 4,
    parameter int H_RES   = 640,
    parameter int V_RES   = 480
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_pix_stb,
    input  logic                       i_animate,
    input  logic [9:0]                 i_x,
    input  logic [8:0]                 i_y,
    input  logic                       i_cfg_valid,
    output logic                       o_cfg_ready,
    input  logic [$clog2(N_SLOTS)-1:0] i_cfg_slot,
    input  logic [11:0]                i_cfg_x,
    input  logic [11:0]                i_cfg_y,
    input  logic [7:0]                 i_cfg_hsize,
    input  logic                       i_cfg_dx_pos,
    input  logic                       i_cfg_dy_pos,
    input  logic                       i_cfg_en,
    input  logic [11:0]                i_cfg_color,
    output logic [11:0]                o_rgb,
    output logic                       o_hit,
    output logic                       o_busy
);

    localparam int IDX_W = $clog2(N_SLOTS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SLOTS - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    slot_t              slots_q [N_SLOTS];
    slot_t              slots_d [N_SLOTS];
    logic [COLOR_W-1:0] rgb_q, rgb_d;
    logic               hit_q, hit_d;

    logic               cfg_fire;
    logic               step_fire;
    slot_t              cur;
    logic [11:0]        nx, ny;
    logic               ndx, ndy;

    assign cur = slots_q[idx_q];

    sprite_axis_step #(.RES(H_RES)) u_step_x (
        .p_i   (cur.x),
        .dir_i (cur.dx_pos),
        .h_i   (cur.hsize),
        .p_o   (nx),
        .dir_o (ndx)
    );

    sprite_axis_step #(.RES(V_RES)) u_step_y (
        .p_i   (cur.y),
        .dir_i (cur.dy_pos),
        .h_i   (cur.hsize),
        .p_o   (ny),
        .dir_o (ndy)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (i_animate) begin
                    state_d = SWEEP;
                    idx_d   = '0;
                end
            end
            SWEEP: begin
                if (i_pix_stb) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        o_cfg_ready = (state_q == IDLE);
        o_busy      = (state_q == SWEEP);
    end

    assign cfg_fire  = i_cfg_valid && o_cfg_ready;
    assign step_fire = (state_q == SWEEP) && i_pix_stb && cur.en;

    // Writes and steps are mutually exclusive: writes only happen in IDLE, steps only in SWEEP.
    always_comb begin
        for (int i = 0; i < N_SLOTS; i++) begin
            slots_d[i] = slots_q[i];
        end
        if (cfg_fire) begin
            slots_d[i_cfg_slot] = '{
                x:      i_cfg_x,
                y:      i_cfg_y,
                hsize:  i_cfg_hsize,
                dx_pos: i_cfg_dx_pos,
                dy_pos: i_cfg_dy_pos,
                en:     i_cfg_en,
                color:  i_cfg_color
            };
        end else if (step_fire) begin
            slots_d[idx_q].x      = nx;
            slots_d[idx_q].y      = ny;
            slots_d[idx_q].dx_pos = ndx;
            slots_d[idx_q].dy_pos = ndy;
        end
    end

    // Walk from the highest index down so the lowest-index hitting slot is the last writer.
    always_comb begin
        logic [COLOR_W-1:0] win_rgb;
        logic               any_hit;
        win_rgb = '0;
        any_hit = 1'b0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (slots_q[i].en
                && span_hit(slots_q[i].x, slots_q[i].hsize, {2'b00, i_x})
                && span_hit(slots_q[i].y, slots_q[i].hsize, {3'b000, i_y})) begin
                win_rgb = slots_q[i].color;
                any_hit = 1'b1;
            end
        end
        rgb_d = rgb_q;
        hit_d = hit_q;
        if (i_pix_stb) begin
            rgb_d = win_rgb;
            hit_d = any_hit;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < N_SLOTS; i++) begin
                slots_q[i] <= SLOT_RESET;
            end
            rgb_q <= '0;
            hit_q <= 1'b0;
        end else begin
            for (int i = 0; i < N_SLOTS; i++) begin
                slots_q[i] <= slots_d[i];
            end
            rgb_q <= rgb_d;
            hit_q <= hit_d;
        end
    end

    assign o_rgb = rgb_q;
    assign o_hit = hit_q;

endmodule
